// File: rtl/mac_fifo_pkg.sv
// mac_fifo_pkg: shared helpers for the MAC frame FIFO.
// Width derivations, sideband layout and write FSM states.
package mac_fifo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int ratio(input int a, input int b);
        return (a > b) ? a / b : b / a;
    endfunction

    function automatic int lanes_w(input int a, input int b);
        return clog2(ratio(a, b)) + 1;
    endfunction

    localparam int SB_LAST  = 0;
    localparam int SB_LANES = 1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wr_state_t;

endpackage

// File: rtl/mac_frame_fifo_if.sv
// mac_frame_fifo_if: write and read handshake bundle.
// slave side is the FIFO, master side is the MAC/host.
interface mac_frame_fifo_if
    import mac_fifo_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int LW             = lanes_w(DATA_IN_WIDTH, DATA_OUT_WIDTH)
) ();
    logic [DATA_IN_WIDTH-1:0]  data_in;
    logic                      data_in_valid;
    logic                      data_in_ready;
    logic                      data_in_last;
    logic                      data_in_error;
    logic [DATA_OUT_WIDTH-1:0] data_out;
    logic                      data_out_valid;
    logic                      data_out_ready;
    logic                      data_out_last;
    logic [LW-1:0]             data_out_lanes;
    logic                      data_out_rewind;

    modport slave (
        input  data_in, data_in_valid, data_in_last, data_in_error,
        input  data_out_ready, data_out_rewind,
        output data_in_ready, data_out, data_out_valid,
        output data_out_last, data_out_lanes
    );

    modport master (
        output data_in, data_in_valid, data_in_last, data_in_error,
        output data_out_ready, data_out_rewind,
        input  data_in_ready, data_out, data_out_valid,
        input  data_out_last, data_out_lanes
    );
endinterface

// File: rtl/mac_fifo_ram.sv
// mac_fifo_ram: simple dual-port storage, registered read.
// Contents are not reset; pointers make stale words unreachable.
module mac_fifo_ram #(
    parameter int AW = 10,
    parameter int DW = 36
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    // write port and registered read port
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mac_frame_fifo.sv
// mac_frame_fifo: frame-aware width-converting FIFO.
// Frames become readable on commit; storage frees on last read beat.
module mac_frame_fifo
    import mac_fifo_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int FIFO_DEPTH     = 10
) (
    input  logic                data_in_clock,
    input  logic                reset,
    mac_frame_fifo_if.slave     bus,
    output logic [FIFO_DEPTH:0] frame_count,
    output logic [FIFO_DEPTH:0] level,
    output logic                overflow
);
    localparam int IW    = DATA_IN_WIDTH;
    localparam int OW    = DATA_OUT_WIDTH;
    localparam int D     = FIFO_DEPTH;
    localparam int W     = (IW > OW) ? IW : OW;
    localparam int RATIO = ratio(IW, OW);
    localparam int LW    = lanes_w(IW, OW);
    localparam int IN_R  = (IW < OW) ? RATIO : 1;
    localparam int OUT_R = (IW > OW) ? RATIO : 1;
    localparam int RW    = W + LW + 1;
    localparam logic [D:0] FULL = {1'b1, {D{1'b0}}};

    logic [D:0]    wr_ptr, commit_ptr, rd_ptr, frame_start;
    logic [D:0]    rd_addr, out_addr;
    wr_state_t     state, state_nx;
    logic [W-1:0]  asm_word, ext, lane_w, wdata_w;
    logic [LW-1:0] asm_cnt, lanes_wr, ridx, out_lanes;
    logic [RW-1:0] wr_word, rd_word;
    logic [W-1:0]  out_word, out_shift;
    logic          full, guard, hs, in_ok, word_done;
    logic          good_last, bad_last, we;
    logic          rd_vld, out_vld, out_last_sb, rewind;
    logic          acc_r, final_lane, out_take, load, fetch, rel;

    assign level    = wr_ptr - frame_start;
    assign full     = (level == FULL);
    assign guard    = (state == W_FILL) && full && (commit_ptr == frame_start);
    assign overflow = guard;
    assign bus.data_in_ready = (state == W_DROP) || guard || !full;
    assign hs = bus.data_in_valid && bus.data_in_ready;

    // write FSM next state; a guard cycle swallows its beat
    always_comb begin
        state_nx = state;
        in_ok    = 1'b0;
        unique case (state)
            W_IDLE: begin
                in_ok = hs;
                if (hs && !bus.data_in_last) state_nx = W_FILL;
            end
            W_FILL: begin
                if (guard) begin
                    state_nx = (hs && bus.data_in_last) ? W_IDLE : W_DROP;
                end else begin
                    in_ok = hs;
                    if (hs && bus.data_in_last) state_nx = W_IDLE;
                end
            end
            W_DROP: begin
                if (hs && bus.data_in_last) state_nx = W_IDLE;
            end
            default: state_nx = W_IDLE;
        endcase
    end

    // place the incoming lane MSB-first into the assembly word
    always_comb begin
        ext = '0;
        ext[W-1 -: IW] = bus.data_in;
        lane_w  = ext >> (int'(asm_cnt) * IW);
        wdata_w = asm_word | lane_w;
    end

    assign word_done = (asm_cnt == LW'(IN_R - 1)) || bus.data_in_last;
    assign good_last = in_ok && bus.data_in_last && !bus.data_in_error;
    assign bad_last  = in_ok && bus.data_in_last && bus.data_in_error;
    assign we        = in_ok && word_done && !bad_last;
    assign lanes_wr  = asm_cnt + 1'b1;
    assign wr_word   = {wdata_w, lanes_wr, bus.data_in_last};

    // write FSM state register
    always_ff @(posedge data_in_clock or posedge reset) begin
        if (reset) state <= W_IDLE;
        else       state <= state_nx;
    end

    // write pointers and assembly register
    always_ff @(posedge data_in_clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            asm_word   <= '0;
            asm_cnt    <= '0;
        end else if (guard || bad_last) begin
            wr_ptr   <= commit_ptr;
            asm_word <= '0;
            asm_cnt  <= '0;
        end else if (in_ok) begin
            if (word_done) begin
                wr_ptr   <= wr_ptr + 1'b1;
                asm_word <= '0;
                asm_cnt  <= '0;
            end else begin
                asm_word <= wdata_w;
                asm_cnt  <= asm_cnt + 1'b1;
            end
            if (bus.data_in_last) commit_ptr <= wr_ptr + 1'b1;
        end
    end

    mac_fifo_ram #(.AW(D), .DW(RW)) u_ram (
        .clock (data_in_clock),
        .we    (we),
        .waddr (wr_ptr[D-1:0]),
        .wdata (wr_word),
        .re    (fetch),
        .raddr (rd_ptr[D-1:0]),
        .rdata (rd_word)
    );

    assign rewind     = bus.data_out_rewind;
    assign acc_r      = out_vld && bus.data_out_ready && !rewind;
    assign final_lane = (ridx == LW'(OUT_R - 1));
    assign out_take   = acc_r && final_lane;
    assign rel        = acc_r && bus.data_out_last;
    assign load       = rd_vld && (!out_vld || out_take) && !rewind;
    assign fetch      = (rd_ptr != commit_ptr) && (!rd_vld || load) && !rewind;

    // read pipeline: RAM stage feeding the show-ahead output register
    always_ff @(posedge data_in_clock or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            rd_addr     <= '0;
            frame_start <= '0;
            rd_vld      <= 1'b0;
            out_vld     <= 1'b0;
            out_word    <= '0;
            out_lanes   <= '0;
            out_last_sb <= 1'b0;
            out_addr    <= '0;
            ridx        <= '0;
        end else if (rewind) begin
            rd_ptr  <= frame_start;
            rd_vld  <= 1'b0;
            out_vld <= 1'b0;
            ridx    <= '0;
        end else begin
            if (fetch) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_addr <= rd_ptr;
                rd_vld  <= 1'b1;
            end else if (load) begin
                rd_vld <= 1'b0;
            end
            if (load) begin
                out_vld     <= 1'b1;
                out_word    <= rd_word[RW-1 -: W];
                out_lanes   <= rd_word[SB_LANES +: LW];
                out_last_sb <= rd_word[SB_LAST];
                out_addr    <= rd_addr;
                ridx        <= '0;
            end else if (out_take) begin
                out_vld <= 1'b0;
                ridx    <= '0;
            end else if (acc_r) begin
                ridx <= ridx + 1'b1;
            end
            if (rel) frame_start <= out_addr + 1'b1;
        end
    end

    // committed-frame counter; commit and release may coincide
    always_ff @(posedge data_in_clock or posedge reset) begin
        if (reset)                  frame_count <= '0;
        else if (good_last && !rel) frame_count <= frame_count + 1'b1;
        else if (rel && !good_last) frame_count <= frame_count - 1'b1;
    end

    // select the current narrow lane, MSB-first
    always_comb begin
        out_shift    = out_word << (int'(ridx) * OW);
        bus.data_out = out_shift[W-1 -: OW];
    end

    assign bus.data_out_valid = out_vld;
    assign bus.data_out_last  = out_vld && out_last_sb && final_lane;
    assign bus.data_out_lanes = out_lanes;
endmodule

// File: tb/tb_mac_frame_fifo.sv
// tb_mac_frame_fifo: scoreboard bench for two width configurations.
// Dut a packs 8->32, dut b unpacks 32->8 with a 16-word store.
module tb_mac_frame_fifo;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_frame_fifo_if #(.DATA_IN_WIDTH(8),  .DATA_OUT_WIDTH(32)) ia ();
    mac_frame_fifo_if #(.DATA_IN_WIDTH(32), .DATA_OUT_WIDTH(8))  ib ();

    logic [10:0] fc_a, lvl_a;
    logic        ovf_a;
    logic [4:0]  fc_b, lvl_b;
    logic        ovf_b;

    mac_frame_fifo #(.DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(32), .FIFO_DEPTH(10)) dut_a (
        .data_in_clock (clk),
        .reset         (reset),
        .bus           (ia),
        .frame_count   (fc_a),
        .level         (lvl_a),
        .overflow      (ovf_a)
    );

    mac_frame_fifo #(.DATA_IN_WIDTH(32), .DATA_OUT_WIDTH(8), .FIFO_DEPTH(4)) dut_b (
        .data_in_clock (clk),
        .reset         (reset),
        .bus           (ib),
        .frame_count   (fc_b),
        .level         (lvl_b),
        .overflow      (ovf_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int acc_b = 0;
    int ovf_cnt = 0;
    int ovf_at = -1;
    logic [35:0] qa[$];
    logic [35:0] qb[$];
    logic [35:0] act_a, exp_a, act_b, exp_b;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] ea(input logic [31:0] d, input logic l, input logic [2:0] n);
        return {d, l, n};
    endfunction

    function automatic logic [35:0] eb(input logic [7:0] d, input logic l);
        return {24'h0, d, l, 3'd1};
    endfunction

    // monitor a: compare every accepted read beat
    always @(negedge clk) begin
        if (!reset && ia.data_out_valid && ia.data_out_ready && !ia.data_out_rewind) begin
            act_a = {ia.data_out, ia.data_out_last, ia.data_out_lanes};
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_beat: got %0h expected no beat", act_a);
            end else begin
                exp_a = qa.pop_front();
                check("a_beat", act_a, exp_a);
            end
        end
    end

    // monitor b: compare every accepted read beat
    always @(negedge clk) begin
        if (!reset && ib.data_out_valid && ib.data_out_ready && !ib.data_out_rewind) begin
            act_b = {24'h0, ib.data_out, ib.data_out_last, ib.data_out_lanes};
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_beat: got %0h expected no beat", act_b);
            end else begin
                exp_b = qb.pop_front();
                check("b_beat", act_b, exp_b);
            end
        end
    end

    // overflow observer for dut b
    always @(negedge clk) begin
        if (!reset && ovf_b) begin
            ovf_cnt++;
            ovf_at = acc_b;
        end
    end

    task automatic send(input int s, input logic [31:0] d, input logic l, input logic e);
        int n;
        logic rdy;
        n = 0;
        if (s == 0) begin
            ia.data_in = d[7:0];
            ia.data_in_last = l;
            ia.data_in_error = e;
            ia.data_in_valid = 1'b1;
        end else begin
            ib.data_in = d;
            ib.data_in_last = l;
            ib.data_in_error = e;
            ib.data_in_valid = 1'b1;
        end
        @(negedge clk);
        rdy = (s == 0) ? ia.data_in_ready : ib.data_in_ready;
        while (!rdy && n < 300) begin
            @(negedge clk);
            rdy = (s == 0) ? ia.data_in_ready : ib.data_in_ready;
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout dut=%0d: got ready=0 expected ready=1", s);
        end
        @(posedge clk);
        #1;
        if (s == 1) acc_b++;
        ia.data_in_valid = 1'b0;
        ia.data_in_last  = 1'b0;
        ia.data_in_error = 1'b0;
        ib.data_in_valid = 1'b0;
        ib.data_in_last  = 1'b0;
        ib.data_in_error = 1'b0;
    endtask

    task automatic wait_drain(input int s, input string nm);
        int n;
        int sz;
        n = 0;
        sz = (s == 0) ? qa.size() : qb.size();
        while (sz != 0 && n < 500) begin
            @(posedge clk);
            #1;
            sz = (s == 0) ? qa.size() : qb.size();
            n++;
        end
        check(nm, sz, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] words [3];
        reset = 1'b1;
        ia.data_in = '0;
        ia.data_in_valid = 1'b0;
        ia.data_in_last = 1'b0;
        ia.data_in_error = 1'b0;
        ia.data_out_ready = 1'b1;
        ia.data_out_rewind = 1'b0;
        ib.data_in = '0;
        ib.data_in_valid = 1'b0;
        ib.data_in_last = 1'b0;
        ib.data_in_error = 1'b0;
        ib.data_out_ready = 1'b0;
        ib.data_out_rewind = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("a_reset_out", {ia.data_in_ready, ia.data_out_valid, ia.data_out_last,
              ia.data_out_lanes, ovf_a, ia.data_out}, {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0});
        check("a_reset_cnt", {fc_a, lvl_a}, 22'h0);
        check("b_reset_out", {ib.data_in_ready, ib.data_out_valid, ib.data_out_last,
              ib.data_out_lanes, ovf_b, ib.data_out}, {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h0});
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 8->32 packing with a zero-padded tail
        qa.push_back(ea(32'h01020304, 1'b0, 3'd4));
        qa.push_back(ea(32'h05060000, 1'b1, 3'd2));
        for (int i = 1; i <= 6; i++) send(0, 32'(i), i == 6, 1'b0);
        wait_drain(0, "a_t1_drain");
        check("a_t1_count", {fc_a, lvl_a}, 22'h0);

        // 32->8 unpacking, frame count up then down
        qb.push_back(eb(8'hA1, 1'b0));
        qb.push_back(eb(8'hB2, 1'b0));
        qb.push_back(eb(8'hC3, 1'b0));
        qb.push_back(eb(8'hD4, 1'b1));
        send(1, 32'hA1B2C3D4, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("b_t2_fc_held", fc_b, 5'd1);
        check("b_t2_lvl_held", lvl_b, 5'd1);
        ib.data_out_ready = 1'b1;
        wait_drain(1, "b_t2_drain");
        check("b_t2_fc_after", fc_b, 5'd0);

        // error frame behind a committed one leaves no trace
        ia.data_out_ready = 1'b0;
        qa.push_back(ea(32'hAABBCCDD, 1'b1, 3'd4));
        send(0, 32'hAA, 1'b0, 1'b0);
        send(0, 32'hBB, 1'b0, 1'b0);
        send(0, 32'hCC, 1'b0, 1'b0);
        send(0, 32'hDD, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 32'hE0 + 32'(i), i == 4, 1'b1);
        check("a_t3_level", lvl_a, 11'd1);
        check("a_t3_fc", fc_a, 11'd1);
        ia.data_out_ready = 1'b1;
        wait_drain(0, "a_t3_drain");
        check("a_t3_level_after", lvl_a, 11'd0);

        // oversize frame on the 16-word store, reader idle
        ib.data_out_ready = 1'b0;
        acc_b = 0;
        ovf_cnt = 0;
        for (int i = 0; i < 20; i++) send(1, 32'h1000 + 32'(i), i == 19, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("b_t4_ovf_pulses", ovf_cnt, 1);
        check("b_t4_ovf_at", ovf_at, 16);
        check("b_t4_level", lvl_b, 5'd0);
        check("b_t4_fc", fc_b, 5'd0);
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC;
        for (int i = 0; i < 3; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++)
                qb.push_back(eb(w[31 - 8 * k -: 8], (i == 2) && (k == 3)));
        end
        for (int i = 0; i < 3; i++) send(1, words[i], i == 2, 1'b0);
        ib.data_out_ready = 1'b1;
        wait_drain(1, "b_t4_drain");

        // partial read, rewind, full replay
        ia.data_out_ready = 1'b0;
        qa.push_back(ea(32'h10111213, 1'b0, 3'd4));
        qa.push_back(ea(32'h14151617, 1'b0, 3'd4));
        qa.push_back(ea(32'h18191A1B, 1'b0, 3'd4));
        qa.push_back(ea(32'h1C1D1E1F, 1'b0, 3'd4));
        qa.push_back(ea(32'h20212223, 1'b1, 3'd4));
        for (int i = 0; i < 20; i++) send(0, 32'h10 + 32'(i), i == 19, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        ia.data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ia.data_out_ready = 1'b0;
        ia.data_out_rewind = 1'b1;
        check("a_t5_consumed", qa.size(), 3);
        qa.delete();
        qa.push_back(ea(32'h10111213, 1'b0, 3'd4));
        qa.push_back(ea(32'h14151617, 1'b0, 3'd4));
        qa.push_back(ea(32'h18191A1B, 1'b0, 3'd4));
        qa.push_back(ea(32'h1C1D1E1F, 1'b0, 3'd4));
        qa.push_back(ea(32'h20212223, 1'b1, 3'd4));
        @(posedge clk);
        #1;
        ia.data_out_rewind = 1'b0;
        check("a_t5_flush", ia.data_out_valid, 1'b0);
        check("a_t5_level", lvl_a, 11'd5);
        check("a_t5_fc", fc_a, 11'd1);
        ia.data_out_ready = 1'b1;
        wait_drain(0, "a_t5_drain");
        check("a_t5_level_after", {fc_a, lvl_a}, 22'h0);

        // reset in the middle of a frame with valid held
        send(0, 32'h31, 1'b0, 1'b0);
        send(0, 32'h32, 1'b0, 1'b0);
        send(0, 32'h33, 1'b0, 1'b0);
        ia.data_in = 8'h77;
        ia.data_in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("a_t6_reset_out", {ia.data_in_ready, ia.data_out_valid, ia.data_out_last,
              ia.data_out_lanes, ovf_a, ia.data_out}, {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0});
        check("a_t6_reset_cnt", {fc_a, lvl_a}, 22'h0);
        repeat (2) @(posedge clk);
        #1;
        ia.data_in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        qa.push_back(ea(32'h5A6B7C8D, 1'b1, 3'd4));
        send(0, 32'h5A, 1'b0, 1'b0);
        send(0, 32'h6B, 1'b0, 1'b0);
        send(0, 32'h7C, 1'b0, 1'b0);
        send(0, 32'h8D, 1'b1, 1'b0);
        wait_drain(0, "a_t6_drain");
        check("a_t6_level_after", {fc_a, lvl_a}, 22'h0);
        check("b_end_queue", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
